// File: rtl/meter_pkg.sv
// Shared constants and types for the parking-meter time core, button decoder and
// display driver.
package meter_pkg;

   localparam int unsigned CNT_W = 14;

   localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(9999);
   localparam logic [CNT_W-1:0] LOW_THRESH = CNT_W'(180);
   localparam logic [CNT_W-1:0] ADD_A      = CNT_W'(60);
   localparam logic [CNT_W-1:0] ADD_B      = CNT_W'(120);
   localparam logic [CNT_W-1:0] ADD_C      = CNT_W'(180);
   localparam logic [CNT_W-1:0] ADD_D      = CNT_W'(300);
   localparam logic [CNT_W-1:0] SET_LO     = CNT_W'(16);
   localparam logic [CNT_W-1:0] SET_HI     = CNT_W'(150);

   // Index 3 is the thousands digit, index 0 the units digit.
   typedef logic [3:0][3:0] bcd4_t;

   typedef enum logic {StIdle, StShift} conv_state_t;

   // Double-dabble correction: any digit >= 5 gets 3 added before the shift.
   function automatic bcd4_t bcd_add3(input bcd4_t v);
      bcd4_t r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (v[i] >= 4'd5) r[i] = v[i] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/meter_counter_if.sv
// Button-pulse inputs and display-facing outputs of the meter time core.
interface meter_counter_if;

   logic       tick_1hz;
   logic       add_a;
   logic       add_b;
   logic       add_c;
   logic       add_d;
   logic       set_lo;
   logic       set_hi;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       state_blink;
   logic       expired;
   logic       busy;

   modport master (
      output tick_1hz, add_a, add_b, add_c, add_d, set_lo, set_hi,
      input  digit3, digit2, digit1, digit0, state_blink, expired, busy
   );

   modport slave (
      input  tick_1hz, add_a, add_b, add_c, add_d, set_lo, set_hi,
      output digit3, digit2, digit1, digit0, state_blink, expired, busy
   );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to four-digit BCD converter, one bit per cycle.
// busy covers the shift cycles plus the cycle in which done is high.
module bin_to_bcd_seq
   import meter_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int unsigned IDX_W = $clog2(CNT_W);

   conv_state_t      state_q, state_d;
   logic [CNT_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [15:0]      adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      adj     = bcd_add3(bcd_q);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StShift;
               bin_d   = bin;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         StShift: begin
            bcd_d = {adj[14:0], bin_q[CNT_W-1]};
            bin_d = {bin_q[CNT_W-2:0], 1'b0};
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(CNT_W - 1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q == StShift) | done_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/meter_counter.sv
// Parking-meter time core: seconds register with coin/set/tick priority logic,
// saturation, blink/expired flags and a dirty-tracked sequential BCD display path.
module meter_counter
   import meter_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   meter_counter_if.slave  bus
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             blink_q;
   logic             expired_q;
   logic             dirty_q, dirty_d;
   bcd4_t            digits_q;

   logic             dec;
   logic             any_add;
   logic [CNT_W-1:0] add_val;
   logic [CNT_W:0]   sum;

   logic             conv_start;
   logic             conv_busy;
   logic             conv_done;
   logic [15:0]      conv_bcd;

   always_comb begin
      dec     = bus.tick_1hz && (count_q != '0);
      any_add = bus.add_a | bus.add_b | bus.add_c | bus.add_d;
      if (bus.add_d)      add_val = ADD_D;
      else if (bus.add_c) add_val = ADD_C;
      else if (bus.add_b) add_val = ADD_B;
      else                add_val = ADD_A;
      // One spare bit so the saturation compare sees the true sum.
      sum = {1'b0, count_q} + {1'b0, add_val} - (CNT_W + 1)'(dec);

      count_d = count_q;
      if (bus.set_hi) begin
         count_d = SET_HI;
      end else if (bus.set_lo) begin
         count_d = SET_LO;
      end else if (any_add) begin
         count_d = (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[CNT_W-1:0];
      end else if (dec) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   assign conv_start = dirty_q & ~conv_busy;

   // A change in the launch cycle itself must still force a later relaunch.
   always_comb begin
      dirty_d = dirty_q;
      if (conv_start) dirty_d = 1'b0;
      if (count_d != count_q) dirty_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         blink_q   <= 1'b1;
         expired_q <= 1'b1;
         dirty_q   <= 1'b0;
         digits_q  <= '0;
      end else begin
         count_q   <= count_d;
         blink_q   <= (count_d < LOW_THRESH);
         expired_q <= (count_d == '0);
         dirty_q   <= dirty_d;
         if (conv_done) digits_q <= conv_bcd;
      end
   end

   bin_to_bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (count_q),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   assign bus.digit3      = digits_q[3];
   assign bus.digit2      = digits_q[2];
   assign bus.digit1      = digits_q[1];
   assign bus.digit0      = digits_q[0];
   assign bus.state_blink = blink_q;
   assign bus.expired     = expired_q;
   assign bus.busy        = conv_busy;

endmodule

// File: tb/tb_meter_counter.sv
// Directed bench for meter_counter: reset, coins, priority, saturation,
// back-to-back conversions and asynchronous reset abort.
module tb_meter_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   meter_counter_if bus ();

   meter_counter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] dig_log [60];
   logic        bsy_log [60];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_in();
      bus.tick_1hz = 1'b0;
      bus.add_a    = 1'b0;
      bus.add_b    = 1'b0;
      bus.add_c    = 1'b0;
      bus.add_d    = 1'b0;
      bus.set_lo   = 1'b0;
      bus.set_hi   = 1'b0;
   endtask

   // Wait until the converter has been idle for three samples in a row.
   task automatic settle();
      int idle = 0;
      int k = 0;
      while (idle < 3 && k < 300) begin
         cyc(1);
         k++;
         idle = bus.busy ? 0 : idle + 1;
      end
      if (idle < 3) check("settle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      int i60;
      int j180;
      int glitches;
      logic seen_busy;

      clear_in();
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // 1: reset state, ticks at zero
      check("t1_digits", digits(), 16'h0000);
      check("t1_blink", bus.state_blink, 1'b1);
      check("t1_expired", bus.expired, 1'b1);
      check("t1_busy", bus.busy, 1'b0);
      seen_busy = 1'b0;
      bus.tick_1hz = 1'b1;
      repeat (20) begin
         cyc(1);
         seen_busy |= bus.busy;
      end
      bus.tick_1hz = 1'b0;
      cyc(2);
      seen_busy |= bus.busy;
      check("t1_tick_busy", seen_busy, 1'b0);
      check("t1_tick_digits", digits(), 16'h0000);
      check("t1_tick_expired", bus.expired, 1'b1);

      // 2: add_d, conversion latency, countdown through the blink threshold
      bus.add_d = 1'b1;
      cyc(1);
      bus.add_d = 1'b0;
      check("t2_blink", bus.state_blink, 1'b0);
      check("t2_expired", bus.expired, 1'b0);
      check("t2_busy_pre", bus.busy, 1'b0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         cyc(1);
         if (bus.busy) n++;
         else if (n > 0) break;
      end
      check("t2_busy_len", n, 15);
      check("t2_digits", digits(), 16'h0300);
      bus.tick_1hz = 1'b1;
      cyc(120);
      check("t2_blink_180", bus.state_blink, 1'b0);
      cyc(1);
      check("t2_blink_179", bus.state_blink, 1'b1);
      bus.tick_1hz = 1'b0;
      settle();
      check("t2_digits_179", digits(), 16'h0179);
      check("t2_expired_179", bus.expired, 1'b0);

      // 3: set priority over add, set swallows tick, add with tick
      bus.set_hi = 1'b1;
      bus.add_d  = 1'b1;
      cyc(1);
      clear_in();
      settle();
      check("t3_set_hi", digits(), 16'h0150);
      check("t3_blink_150", bus.state_blink, 1'b1);
      bus.set_lo   = 1'b1;
      bus.tick_1hz = 1'b1;
      cyc(1);
      clear_in();
      settle();
      check("t3_set_lo", digits(), 16'h0016);
      bus.add_a    = 1'b1;
      bus.tick_1hz = 1'b1;
      cyc(1);
      clear_in();
      settle();
      check("t3_add_tick", digits(), 16'h0075);

      // 4: saturation
      bus.set_hi = 1'b1;
      cyc(1);
      clear_in();
      bus.add_d = 1'b1;
      cyc(32);
      bus.add_d = 1'b0;
      bus.add_a = 1'b1;
      cyc(1);
      bus.add_a    = 1'b0;
      bus.tick_1hz = 1'b1;
      cyc(10);
      bus.tick_1hz = 1'b0;
      settle();
      check("t4_9800", digits(), 16'h9800);
      check("t4_blink_9800", bus.state_blink, 1'b0);
      bus.add_d = 1'b1;
      cyc(1);
      bus.add_d = 1'b0;
      settle();
      check("t4_sat", digits(), 16'h9999);
      bus.add_a    = 1'b1;
      bus.tick_1hz = 1'b1;
      cyc(1);
      clear_in();
      seen_busy = 1'b0;
      repeat (5) begin
         cyc(1);
         seen_busy |= bus.busy;
      end
      check("t4_sat_tick_busy", seen_busy, 1'b0);
      check("t4_sat_tick", digits(), 16'h9999);
      check("t4_expired", bus.expired, 1'b0);

      // 5: back-to-back changes with a dirty relaunch
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      bus.add_a = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         dig_log[k] = digits();
         bsy_log[k] = bus.busy;
         bus.add_a = 1'b0;
         bus.add_b = (k == 3);
      end
      i60 = -1;
      j180 = -1;
      glitches = 0;
      for (int k = 0; k < 60; k++) begin
         if (dig_log[k] == 16'h0060 && i60 < 0) i60 = k;
         if (dig_log[k] == 16'h0180 && j180 < 0) j180 = k;
         if (dig_log[k] != 16'h0000 && dig_log[k] != 16'h0060 && dig_log[k] != 16'h0180)
            glitches++;
      end
      check("t5_first_write", i60, 16);
      check("t5_second_write", j180, 32);
      check("t5_glitches", glitches, 0);
      if (i60 >= 0 && i60 < 59) begin
         check("t5_idle_at_write", bsy_log[i60], 1'b0);
         check("t5_relaunch", bsy_log[i60+1], 1'b1);
      end else begin
         check("t5_write_missing", 32'd1, 32'd0);
      end
      check("t5_final", dig_log[59], 16'h0180);

      // 6: asynchronous reset mid-conversion
      bus.add_b = 1'b1;
      cyc(1);
      bus.add_b = 1'b0;
      cyc(5);
      check("t6_busy_mid", bus.busy, 1'b1);
      check("t6_digits_mid", digits(), 16'h0180);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_digits", digits(), 16'h0000);
      check("t6_rst_blink", bus.state_blink, 1'b1);
      check("t6_rst_expired", bus.expired, 1'b1);
      check("t6_rst_busy", bus.busy, 1'b0);
      cyc(2);
      rst_n = 1'b1;
      seen_busy = 1'b0;
      bus.tick_1hz = 1'b1;
      repeat (10) begin
         cyc(1);
         seen_busy |= bus.busy;
      end
      bus.tick_1hz = 1'b0;
      cyc(2);
      seen_busy |= bus.busy;
      check("t6_tick_busy", seen_busy, 1'b0);
      check("t6_tick_digits", digits(), 16'h0000);
      check("t6_tick_expired", bus.expired, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
